rr_mux_arb: RTL and testbench

Parametrised N-input, valid/ready arbitrating multiplexer with a registered output stage. It is the successor to the CPU's fixed 4-way combinational select muxes. It steers one of N requesting sources onto a single shared sink: round-robin or fixed priority, one-cycle latency, full throughput. It is intended for shared-resource ports such as a memory bus shared between instruction fetch, data access and debug.

---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_grant.sv | 37 +++
 rtl/rr_mux_arb.sv | 62 ++++++
 tb/tb_rr_mux_arb.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared arbitration mode type and grant-index width helper.
//   ARB_FIXED - lowest valid index wins
//   ARB_RR    - round-robin starting at the priority pointer
//   sel_w(n)  - width of an index into n channels, at least 1 bit
package arb_pkg;
    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational one-hot grant selection, round-robin or fixed priority.
//   req       in  N     per-channel request
//   ptr       in  SELW  first channel scanned in ARB_RR (must be < N)
//   mode      in  1     ARB_RR or ARB_FIXED (ptr ignored in ARB_FIXED)
//   grant     out N     one-hot grant, zero when no request
//   grant_idx out SELW  index of the granted channel, 0 when no request
module rr_grant import arb_pkg::*; #(
    parameter int N = 4,
    localparam int SELW = sel_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  arb_mode_t       mode,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx
);
    logic found;
    int   j;

    // Scan N positions from the start point; the explicit subtract keeps the
    // wrap correct for non-power-of-2 N.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = (mode == ARB_RR) ? int'(ptr) + k : k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = SELW'(j);
            end
        end
    end
endmodule

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-input valid/ready arbitrating mux with a registered output stage.
//   clk       in  1        rising-edge clock
//   rst       in  1        synchronous active-high reset
//   in_valid  in  N        per-channel request
//   in_data   in  N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_ready  out N        per-channel accept, combinational
//   out_valid out 1        output register holds a beat
//   out_data  out WIDTH    registered data
//   out_sel   out SELW     channel that sourced out_data
//   out_ready in  1        sink accepts the current beat
// Integrators: out_ready -> in_ready is a combinational path. There is no
// combinational path from in_valid/in_data to any out_* signal.
module rr_mux_arb import arb_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int N = 4,
    parameter arb_mode_t MODE = ARB_RR,
    localparam int SELW = sel_w(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);
    logic [SELW-1:0] ptr;
    logic [N-1:0]    grant;
    logic [SELW-1:0] grant_idx;
    logic            load;

    rr_grant #(.N(N)) u_grant (
        .req       (in_valid),
        .ptr       (ptr),
        .mode      (MODE),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Register may load when empty or when its beat drains this same cycle.
    assign load     = !out_valid || out_ready;
    assign in_ready = grant & {N{load}};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= |grant;
            if (|grant) begin
                out_data <= in_data[int'(grant_idx) * WIDTH +: WIDTH];
                out_sel  <= grant_idx;
                if (MODE == ARB_RR)
                    ptr <= (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: directed self-checking bench for rr_mux_arb (RR N=4, FIXED N=4, RR N=3).
module tb_rr_mux_arb;
    import arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic         rst4, rstf, rst3;
    logic [3:0]   v4, vf;
    logic [2:0]   v3;
    logic [127:0] d4, df;
    logic [95:0]  d3;
    logic [3:0]   r4, rf;
    logic [2:0]   r3;
    logic         ov4, ovf, ov3;
    logic [31:0]  od4, odf, od3;
    logic [1:0]   os4, osf, os3;
    logic         ordy4, ordyf, ordy3;

    rr_mux_arb #(.WIDTH(32), .N(4), .MODE(ARB_RR)) u4 (
        .clk(clk), .rst(rst4), .in_valid(v4), .in_data(d4), .in_ready(r4),
        .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(ordy4));

    rr_mux_arb #(.WIDTH(32), .N(4), .MODE(ARB_FIXED)) uf (
        .clk(clk), .rst(rstf), .in_valid(vf), .in_data(df), .in_ready(rf),
        .out_valid(ovf), .out_data(odf), .out_sel(osf), .out_ready(ordyf));

    rr_mux_arb #(.WIDTH(32), .N(3), .MODE(ARB_RR)) u3 (
        .clk(clk), .rst(rst3), .in_valid(v3), .in_data(d3), .in_ready(r3),
        .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(ordy3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst4 = 1'b1; rstf = 1'b1; rst3 = 1'b1;
        v4 = 4'b1111; vf = 4'b0000; v3 = 3'b000;
        d4 = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
        df = {32'hF000_0003, 32'hF000_0002, 32'hF000_0001, 32'hF000_0000};
        d3 = {32'h3000_0002, 32'h3000_0001, 32'h3000_0000};
        ordy4 = 1'b1; ordyf = 1'b1; ordy3 = 1'b1;

        // reset held two cycles with all inputs valid
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_valid", 32'(ov4), 32'd0);
            chk("rst_sel", 32'(os4), 32'd0);
            chk("rst_data", od4, 32'd0);
            chk("rst_ptr", 32'(u4.ptr), 32'd0);
        end
        chk("rst_in_ready", 32'(r4), 32'b0001);
        rst4 = 1'b0;

        // round-robin fairness, one beat per cycle
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("rr_valid", 32'(ov4), 32'd1);
            chk("rr_sel", 32'(os4), 32'(c % 4));
            chk("rr_data", od4, 32'h1000_0000 + 32'(c % 4));
        end
        chk("rr_ptr", 32'(u4.ptr), 32'd3);

        // load A5 beat from channel 2 (scan 3,0,1,2), ptr returns to 3
        v4 = 4'b0100;
        d4[64 +: 32] = 32'hA5A5_A5A5;
        tick();
        chk("bp_load_sel", 32'(os4), 32'd2);
        chk("bp_load_data", od4, 32'hA5A5_A5A5);
        chk("bp_load_ptr", 32'(u4.ptr), 32'd3);

        // stall for 5 cycles
        ordy4 = 1'b0;
        v4 = 4'b1111;
        #1;
        chk("bp_in_ready", 32'(r4), 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_data", od4, 32'hA5A5_A5A5);
            chk("bp_sel", 32'(os4), 32'd2);
            chk("bp_valid", 32'(ov4), 32'd1);
            chk("bp_ready", 32'(r4), 32'd0);
            chk("bp_ptr", 32'(u4.ptr), 32'd3);
        end

        // drain and load channel 3 on the same edge
        ordy4 = 1'b1;
        v4 = 4'b1000;
        #1;
        chk("drain_in_ready", 32'(r4), 32'b1000);
        tick();
        chk("drain_valid", 32'(ov4), 32'd1);
        chk("drain_sel", 32'(os4), 32'd3);
        chk("drain_data", od4, 32'h1000_0003);
        chk("wrap_ptr", 32'(u4.ptr), 32'd0);

        // no requester: register empties, data/sel hold
        v4 = 4'b0000;
        tick();
        chk("idle_valid", 32'(ov4), 32'd0);
        chk("idle_sel", 32'(os4), 32'd3);
        chk("idle_data", od4, 32'h1000_0003);

        // reset mid-stream with out_valid=1 and ptr=2
        v4 = 4'b0010;
        tick();
        chk("mid_pre_valid", 32'(ov4), 32'd1);
        chk("mid_pre_ptr", 32'(u4.ptr), 32'd2);
        rst4 = 1'b1;
        v4 = 4'b1111;
        tick();
        chk("mid_rst_valid", 32'(ov4), 32'd0);
        chk("mid_rst_ptr", 32'(u4.ptr), 32'd0);
        rst4 = 1'b0;
        tick();
        chk("mid_after_sel", 32'(os4), 32'd0);
        chk("mid_after_data", od4, 32'h1000_0000);

        // fixed priority
        rstf = 1'b0;
        vf = 4'b1010;
        #1;
        chk("fx_in_ready", 32'(rf), 32'b0010);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("fx_sel", 32'(osf), 32'd1);
            chk("fx_data", odf, 32'hF000_0001);
            chk("fx_ready", 32'(rf), 32'b0010);
        end
        vf = 4'b1000;
        tick();
        chk("fx_drop_sel", 32'(osf), 32'd3);
        chk("fx_drop_data", odf, 32'hF000_0003);

        // N=3 wrap
        rst3 = 1'b0;
        v3 = 3'b111;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("n3_sel", 32'(os3), 32'(c % 3));
            chk("n3_data", od3, 32'h3000_0000 + 32'(c % 3));
            chk("n3_ptr", 32'(u3.ptr), 32'((c + 1) % 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
